prefix_add_sequencer: RTL

- Multi-cycle controller that computes one WIDTH-bit addition by time-multiplexing a single SEG-bit parallel-prefix adder, one segment per cycle.
- Ripples the carry between segments in a register and accumulates the sum.
- Sits between the execute stage and the shared prefix adder instance; the adder stays purely combinational and outside this block.

---
 rtl/prefix_add_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/prefix_add_sequencer.sv
// prefix_add_sequencer
// Multi-cycle controller that performs one WIDTH-bit addition by feeding a
// shared SEG-bit combinational adder one segment per cycle, rippling the
// carry between segments in a register. The completed result is published
// on sum/cout only when the last segment is done, so an aborted operation
// leaves the previous result visible.
// Optional feature macro: PREFIX_ADD_SEQ_OVF_EN adds the signed-overflow
// output ovf.
module prefix_add_sequencer #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [SEG-1:0]   add_a,
    output logic [SEG-1:0]   add_b,
    output logic             add_cin,
    input  logic [SEG-1:0]   add_sum,
    input  logic             add_cout
`ifdef PREFIX_ADD_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSEG = WIDTH / SEG;
    localparam int IDXW = (NSEG > 1) ? $clog2(NSEG) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [IDXW-1:0]  idx_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             cin_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] sum_reg;      // shadow accumulator, discarded on abort
    logic [WIDTH-1:0] sum_out_reg;  // published result
    logic             cout_reg;
    logic [WIDTH-1:0] sum_next;
    logic             last_seg;

    logic [SEG-1:0] a_seg [NSEG];
    logic [SEG-1:0] b_seg [NSEG];

    assign last_seg = (idx_reg == IDXW'(NSEG - 1));

    // Slice operands into segments and merge the current adder sum into the
    // shadow accumulator at the active segment position.
    generate
        for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
            assign a_seg[gi] = a_reg[gi*SEG +: SEG];
            assign b_seg[gi] = b_reg[gi*SEG +: SEG];
            assign sum_next[gi*SEG +: SEG] =
                (idx_reg == IDXW'(gi)) ? add_sum : sum_reg[gi*SEG +: SEG];
        end
    endgenerate

    assign ready = (state_reg == S_IDLE);
    assign busy  = (state_reg == S_RUN);
    assign done  = (state_reg == S_DONE);
    assign sum   = sum_out_reg;
    assign cout  = cout_reg;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and shared-adder drive; adder inputs stay at zero
    // outside RUN so the adder only toggles while busy.
    always_comb begin
        state_next = state_reg;
        add_a      = '0;
        add_b      = '0;
        add_cin    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                add_a   = a_seg[idx_reg];
                add_b   = b_seg[idx_reg];
                add_cin = (idx_reg == '0) ? cin_reg : carry_reg;
                if (abort) begin
                    state_next = S_IDLE;
                end else if (last_seg) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, per-segment accumulation and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg     <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            cin_reg     <= 1'b0;
            carry_reg   <= 1'b0;
            sum_reg     <= '0;
            sum_out_reg <= '0;
            cout_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        a_reg   <= op_a;
                        b_reg   <= op_b;
                        cin_reg <= op_cin;
                        idx_reg <= '0;
                    end
                end
                S_RUN: begin
                    if (!abort) begin
                        sum_reg   <= sum_next;
                        carry_reg <= add_cout;
                        if (last_seg) begin
                            sum_out_reg <= sum_next;
                            cout_reg    <= add_cout;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PREFIX_ADD_SEQ_OVF_EN
    logic ovf_reg;
    logic ovf_next;

    // Signed overflow: operands share a sign and the result sign differs.
    assign ovf_next = (add_a[SEG-1] ~^ add_b[SEG-1]) & (add_a[SEG-1] ^ add_sum[SEG-1]);
    assign ovf      = ovf_reg;

    // Overflow flag is published alongside sum/cout on the last segment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == S_RUN && !abort && last_seg) begin
            ovf_reg <= ovf_next;
        end
    end
`endif

endmodule
